// File: rtl/read_return_collector.sv
// Collects DDR2 read-return beats against a FIFO of outstanding read tags,
// checks each beat's address and hands the words to the host through a data FIFO.
//
// state       | meaning
// ------------+-------------------------------------------------------------
// ST_IDLE     | no burst in progress; a beat here opens the oldest tag
// ST_COLLECT  | burst open; every beat advances the index until the last one
module read_return_collector #(
    parameter int REQ_DEPTH  = 4,
    parameter int DATA_DEPTH = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic [24:0] req_addr,
    input  logic [1:0]  req_sz,
    output logic        req_ready,
    input  logic        validout,
    input  logic [15:0] dout,
    input  logic [24:0] raddr,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_data,
    output logic [24:0] out_addr,
    output logic        out_last,
    output logic        done,
    output logic        busy,
    output logic        err_addr,
    output logic        err_unexp,
    output logic        err_ovf,
    output logic [15:0] req_count
);

    localparam int RAW = $clog2(REQ_DEPTH);
    localparam int DAW = $clog2(DATA_DEPTH);

    typedef enum logic {ST_IDLE, ST_COLLECT} state_t;

    state_t state, state_next;

    logic [26:0]  tag_mem [REQ_DEPTH];
    logic [RAW-1:0] tag_wr, tag_rd;
    logic [RAW:0]   tag_cnt;
    logic         tag_push, tag_pop, tag_empty;
    logic [24:0]  head_addr;
    logic [1:0]   head_sz;

    logic [41:0]  data_mem [DATA_DEPTH];
    logic [DAW-1:0] data_wr, data_rd;
    logic [DAW:0]   data_cnt;
    logic         data_push, data_pop, data_full;
    logic [41:0]  data_head;

    logic [24:0]  cur_addr;
    logic [1:0]   cur_sz;
    logic [4:0]   beat_cnt;
    logic         beat_take, beat_last, beat_unexp;
    logic [24:0]  beat_base;
    logic [4:0]   beat_idx;
    logic [24:0]  exp_addr;

    // Tag FIFO
    assign req_ready = (tag_cnt != (RAW+1)'(REQ_DEPTH));
    assign tag_empty = (tag_cnt == '0);
    assign tag_push  = req_valid & req_ready;
    assign head_addr = tag_mem[tag_rd][26:2];
    assign head_sz   = tag_mem[tag_rd][1:0];

    always_ff @(posedge clk) begin
        if (tag_push)
            tag_mem[tag_wr] <= {req_addr, req_sz};
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            tag_wr  <= '0;
            tag_rd  <= '0;
            tag_cnt <= '0;
        end else begin
            if (tag_push)
                tag_wr <= tag_wr + RAW'(1);
            if (tag_pop)
                tag_rd <= tag_rd + RAW'(1);
            case ({tag_push, tag_pop})
                2'b10:   tag_cnt <= tag_cnt + (RAW+1)'(1);
                2'b01:   tag_cnt <= tag_cnt - (RAW+1)'(1);
                default: tag_cnt <= tag_cnt;
            endcase
        end
    end

    // Burst sequencing
    always_ff @(posedge clk) begin
        if (!reset)
            state <= ST_IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        tag_pop    = 1'b0;
        beat_take  = 1'b0;
        beat_last  = 1'b0;
        beat_unexp = 1'b0;
        beat_base  = cur_addr;
        beat_idx   = beat_cnt;
        case (state)
            ST_IDLE: begin
                if (validout) begin
                    if (!tag_empty) begin
                        tag_pop    = 1'b1;
                        beat_take  = 1'b1;
                        beat_base  = head_addr;
                        beat_idx   = '0;
                        state_next = ST_COLLECT;
                    end else begin
                        beat_unexp = 1'b1;
                    end
                end
            end
            ST_COLLECT: begin
                if (validout) begin
                    beat_take = 1'b1;
                    beat_last = (beat_cnt == {cur_sz, 3'b111});
                    if (beat_last)
                        state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Beat 0 of a burst is never its last beat, since the shortest burst is 8.
    assign exp_addr = beat_base + {20'd0, beat_idx};
    assign busy     = (state == ST_COLLECT);

    always_ff @(posedge clk) begin
        if (!reset) begin
            cur_addr  <= '0;
            cur_sz    <= '0;
            beat_cnt  <= '0;
            done      <= 1'b0;
            req_count <= '0;
            err_addr  <= 1'b0;
            err_unexp <= 1'b0;
            err_ovf   <= 1'b0;
        end else begin
            done <= beat_take & beat_last;
            if (beat_take & beat_last & (req_count != 16'hFFFF))
                req_count <= req_count + 16'd1;
            if (tag_pop) begin
                cur_addr <= head_addr;
                cur_sz   <= head_sz;
                beat_cnt <= 5'd1;
            end else if (beat_take) begin
                beat_cnt <= beat_last ? 5'd0 : beat_cnt + 5'd1;
            end
            if (beat_take && (raddr != exp_addr))
                err_addr <= 1'b1;
            if (beat_unexp)
                err_unexp <= 1'b1;
            if (beat_take && !data_push)
                err_ovf <= 1'b1;
        end
    end

    // Data FIFO; a full FIFO still takes a beat when the host pops the same cycle.
    assign out_valid = (data_cnt != '0);
    assign data_full = (data_cnt == (DAW+1)'(DATA_DEPTH));
    assign data_pop  = out_valid & out_ready;
    assign data_push = beat_take & (!data_full | data_pop);
    assign data_head = data_mem[data_rd];
    assign out_data  = out_valid ? data_head[41:26] : '0;
    assign out_addr  = out_valid ? data_head[25:1]  : '0;
    assign out_last  = out_valid & data_head[0];

    always_ff @(posedge clk) begin
        if (data_push)
            data_mem[data_wr] <= {dout, raddr, beat_last};
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            data_wr  <= '0;
            data_rd  <= '0;
            data_cnt <= '0;
        end else begin
            if (data_push)
                data_wr <= data_wr + DAW'(1);
            if (data_pop)
                data_rd <= data_rd + DAW'(1);
            case ({data_push, data_pop})
                2'b10:   data_cnt <= data_cnt + (DAW+1)'(1);
                2'b01:   data_cnt <= data_cnt - (DAW+1)'(1);
                default: data_cnt <= data_cnt;
            endcase
        end
    end

endmodule

// File: tb/tb_read_return_collector.sv
// Bench for read_return_collector: directed scenarios plus a random phase, all
// checked each cycle against a queue-based model of the collector's rules.
module tb_read_return_collector;

    localparam int REQ_DEPTH  = 4;
    localparam int DATA_DEPTH = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic [24:0] req_addr;
    logic [1:0]  req_sz;
    logic        req_ready;
    logic        validout;
    logic [15:0] dout;
    logic [24:0] raddr;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic [24:0] out_addr;
    logic        out_last;
    logic        done;
    logic        busy;
    logic        err_addr;
    logic        err_unexp;
    logic        err_ovf;
    logic [15:0] req_count;

    always #5 clk = ~clk;

    read_return_collector #(.REQ_DEPTH(REQ_DEPTH), .DATA_DEPTH(DATA_DEPTH)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_addr(req_addr), .req_sz(req_sz), .req_ready(req_ready),
        .validout(validout), .dout(dout), .raddr(raddr),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_addr(out_addr), .out_last(out_last),
        .done(done), .busy(busy), .err_addr(err_addr), .err_unexp(err_unexp),
        .err_ovf(err_ovf), .req_count(req_count)
    );

    typedef struct {logic [24:0] addr; logic [1:0] sz;} tag_t;
    typedef struct {logic [15:0] data; logic [24:0] addr; logic last;} word_t;

    int checks = 0;
    int errors = 0;

    tag_t        m_tags[$];
    word_t       m_words[$];
    bit          m_in_burst;
    logic [24:0] m_base;
    int          m_idx, m_beats, m_count;
    bit          m_done, m_ea, m_eu, m_eo;

    int done_seen, words_seen, last_seen;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        m_tags.delete();
        m_words.delete();
        m_in_burst = 0; m_base = '0; m_idx = 0; m_beats = 0; m_count = 0;
        m_done = 0; m_ea = 0; m_eu = 0; m_eo = 0;
    endtask

    // One clock edge of the collector's behaviour, computed from the pre-edge inputs.
    task automatic model_step();
        int          tags_pre;
        bit          pop_out, accept, last;
        tag_t        t;
        word_t       w;
        logic [24:0] expa;
        if (!reset) begin
            model_clear();
            return;
        end
        tags_pre = m_tags.size();
        pop_out  = out_ready && (m_words.size() > 0);
        m_done   = 0;
        if (validout) begin
            if (!m_in_burst && tags_pre > 0) begin
                t = m_tags.pop_front();
                m_in_burst = 1; m_base = t.addr; m_idx = 0;
                m_beats = (int'(t.sz) + 1) * 8;
            end else if (!m_in_burst) begin
                m_eu = 1;
            end
            if (m_in_burst) begin
                expa = m_base + 25'(m_idx);
                if (raddr !== expa) m_ea = 1;
                last   = (m_idx == m_beats - 1);
                accept = (m_words.size() < DATA_DEPTH) || pop_out;
                w.data = dout; w.addr = raddr; w.last = last;
                if (pop_out) begin
                    void'(m_words.pop_front());
                    pop_out = 0;
                end
                if (accept) m_words.push_back(w);
                else m_eo = 1;
                m_idx++;
                if (last) begin
                    m_in_burst = 0;
                    m_done = 1;
                    if (m_count < 65535) m_count++;
                end
            end
        end
        if (pop_out) void'(m_words.pop_front());
        if (req_valid && tags_pre < REQ_DEPTH) begin
            t.addr = req_addr; t.sz = req_sz;
            m_tags.push_back(t);
        end
    endtask

    task automatic compare_all();
        chk("req_ready", req_ready, m_tags.size() < REQ_DEPTH);
        chk("out_valid", out_valid, m_words.size() != 0);
        if (m_words.size() != 0) begin
            chk("out_data", out_data, m_words[0].data);
            chk("out_addr", out_addr, m_words[0].addr);
            chk("out_last", out_last, m_words[0].last);
        end else begin
            chk("out_data_idle", out_data, 0);
            chk("out_addr_idle", out_addr, 0);
            chk("out_last_idle", out_last, 0);
        end
        chk("done", done, m_done);
        chk("busy", busy, m_in_burst);
        chk("err_addr", err_addr, m_ea);
        chk("err_unexp", err_unexp, m_eu);
        chk("err_ovf", err_ovf, m_eo);
        chk("req_count", req_count, m_count);
    endtask

    task automatic cycle();
        if (reset && out_valid && out_ready) begin
            words_seen++;
            if (out_last) last_seen++;
        end
        model_step();
        @(posedge clk);
        #1;
        if (done) done_seen++;
        compare_all();
    endtask

    task automatic clear_seen();
        done_seen = 0; words_seen = 0; last_seen = 0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic do_reset();
        reset = 1'b0;
        cycle();
        cycle();
        reset = 1'b1;
        cycle();
    endtask

    task automatic push_req(input logic [24:0] a, input logic [1:0] s);
        req_valid = 1'b1; req_addr = a; req_sz = s;
        cycle();
        req_valid = 1'b0;
    endtask

    task automatic send_beats(input logic [24:0] base, input int first, input int n);
        for (int i = first; i < first + n; i++) begin
            validout = 1'b1;
            raddr    = base + 25'(i);
            dout     = 16'($urandom);
            cycle();
        end
        validout = 1'b0;
    endtask

    tag_t        four[4];
    logic [24:0] a_tmp;
    int          rnd_sel;

    initial begin
        reset = 1'b0; req_valid = 1'b0; req_addr = '0; req_sz = '0;
        validout = 1'b0; dout = '0; raddr = '0; out_ready = 1'b0;
        model_clear();
        clear_seen();

        // Reset state
        do_reset();
        chk("rst_req_ready", req_ready, 1);
        chk("rst_req_count", req_count, 0);

        // Single 8-beat burst
        out_ready = 1'b1;
        clear_seen();
        push_req(25'h0000100, 2'd0);
        send_beats(25'h0000100, 0, 8);
        idle(3);
        chk("b8_words", words_seen, 8);
        chk("b8_last", last_seen, 1);
        chk("b8_done", done_seen, 1);
        chk("b8_count", req_count, 1);
        chk("b8_err_addr", err_addr, 0);

        // Address wrap at the top of the 25-bit space
        push_req(25'h1FFFFFC, 2'd0);
        send_beats(25'h1FFFFFC, 0, 8);
        idle(3);
        chk("wrap_err_addr", err_addr, 0);
        chk("wrap_count", req_count, 2);

        // Beat with no outstanding request
        do_reset();
        validout = 1'b1; raddr = 25'($urandom); dout = 16'($urandom);
        cycle();
        validout = 1'b0;
        idle(1);
        chk("unexp_flag", err_unexp, 1);
        chk("unexp_out_valid", out_valid, 0);

        // 32-beat burst into a stalled host: overflow after 16 words
        do_reset();
        out_ready = 1'b0;
        clear_seen();
        push_req(25'h0ABCDE0, 2'd3);
        send_beats(25'h0ABCDE0, 0, 32);
        idle(2);
        chk("ovf_done", done_seen, 1);
        chk("ovf_flag", err_ovf, 1);
        chk("ovf_count", req_count, 1);
        out_ready = 1'b1;
        clear_seen();
        idle(20);
        chk("ovf_words", words_seen, 16);

        // Tag FIFO full: fifth request ignored
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            four[i].addr = 25'($urandom);
            four[i].sz   = 2'($urandom);
            push_req(four[i].addr, four[i].sz);
        end
        chk("full_req_ready", req_ready, 0);
        push_req(25'h1234567, 2'd0);
        for (int i = 0; i < 4; i++)
            send_beats(four[i].addr, 0, (int'(four[i].sz) + 1) * 8);
        idle(3);
        chk("full_count", req_count, 4);
        chk("full_err_addr", err_addr, 0);
        chk("full_err_unexp", err_unexp, 0);

        // Reset in the middle of a burst
        do_reset();
        clear_seen();
        a_tmp = 25'($urandom);
        push_req(a_tmp, 2'd1);
        send_beats(a_tmp, 0, 3);
        reset = 1'b0; validout = 1'b1; raddr = a_tmp + 25'd3;
        cycle();
        reset = 1'b1; validout = 1'b0;
        cycle();
        chk("mid_rst_count", req_count, 0);
        chk("mid_rst_done", done_seen, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_out_valid", out_valid, 0);
        a_tmp = 25'($urandom);
        push_req(a_tmp, 2'd1);
        send_beats(a_tmp, 0, 16);
        idle(3);
        chk("mid_rst_next_count", req_count, 1);
        chk("mid_rst_next_err", {err_addr, err_unexp, err_ovf}, 0);

        // Random traffic against the model
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            req_valid = ($urandom_range(0, 3) == 0);
            req_addr  = ($urandom_range(0, 3) == 0) ? 25'h1FFFFF0 + 25'($urandom_range(0, 15))
                                                    : 25'($urandom);
            req_sz    = 2'($urandom);
            if (m_in_burst || m_tags.size() > 0)
                validout = ($urandom_range(0, 3) != 0);
            else
                validout = ($urandom_range(0, 15) == 0);
            if (m_in_burst)
                raddr = m_base + 25'(m_idx);
            else if (m_tags.size() > 0)
                raddr = m_tags[0].addr;
            else
                raddr = 25'($urandom);
            rnd_sel = $urandom_range(0, 63);
            if (rnd_sel == 0)
                raddr = raddr ^ 25'h0000010;
            dout      = 16'($urandom);
            out_ready = ($urandom_range(0, 2) != 0);
            cycle();
        end
        req_valid = 1'b0; validout = 1'b0;
        idle(4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
